// File: rtl/nand_flash_emu.sv
// Single-die NAND flash emulator: decodes controller command/address/data cycles into a page array.
// Optional 70h status read is built only when NAND_EMU_STATUS_READ_EN is defined.
module nand_flash_emu #(
  parameter int unsigned PAGE_SIZE   = 32,
  parameter int unsigned PAGES       = 16,
  parameter int unsigned ADDR_CYCLES = 3,
  parameter int unsigned T_RST       = 4,
  parameter int unsigned T_R         = 8,
  parameter int unsigned T_PROG      = 16
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB,
  output logic [7:0] busy_cnt,
  output logic [7:0] page_prog_cnt
);
  localparam int unsigned COL_W = $clog2(PAGE_SIZE);
  localparam int unsigned ROW_W = $clog2(PAGES);
  localparam logic [3:0] N_ADDR = 4'(ADDR_CYCLES);

  typedef enum logic [2:0] {
    StIdle, StRaddr, StWaddr, StDin, StBusyR, StBusyP, StBusyX, StDout
  } state_e;

  state_e           state;
  logic             wen_q, ren_q;
  logic [COL_W-1:0] column;
  logic [ROW_W-1:0] row;
  logic [3:0]       addr_cnt;
  logic [7:0]       dout_q;
  logic [7:0]       pbuf [PAGE_SIZE];
  // Stored inverted so a zero-initialised RAM powers up as an erased (FFh) array.
  logic [7:0]       mem_n [PAGES][PAGE_SIZE];

  logic [7:0] io_in;
  logic       wen_rise, ren_rise, is_cmd, is_addr, is_data, cmd_reset;
  logic       cmd_slot, buf_fill, buf_wr, commit, host_owns_bus;
  logic       io_oe;
  logic [7:0] io_out;

  assign io_in         = F_IO;
  assign wen_rise      = ~wen_q & F_WEN;
  assign ren_rise      = ~ren_q & F_REN;
  assign is_cmd        = wen_rise & F_CLE & ~F_ALE;
  assign is_addr       = wen_rise & ~F_CLE & F_ALE;
  assign is_data       = wen_rise & ~F_CLE & ~F_ALE;
  assign cmd_reset     = is_cmd && (io_in == 8'hFF);
  assign cmd_slot      = F_RB && (state == StIdle || state == StDout);
  assign buf_fill      = is_cmd && cmd_slot && (io_in == 8'h80);
  assign buf_wr        = is_data && F_RB && (state == StDin);
  assign commit        = (state == StBusyP) && (busy_cnt <= 8'd1) && !cmd_reset;
  // The data bus is released whenever the controller presents a command or address.
  assign host_owns_bus = F_CLE | F_ALE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= StIdle;
      wen_q         <= 1'b1;
      ren_q         <= 1'b1;
      column        <= '0;
      row           <= '0;
      addr_cnt      <= '0;
      dout_q        <= '0;
      F_RB          <= 1'b1;
      busy_cnt      <= '0;
      page_prog_cnt <= '0;
    end else begin
      wen_q  <= F_WEN;
      ren_q  <= F_REN;
      dout_q <= ~mem_n[row][column];
      if (cmd_reset) begin
        state    <= StBusyX;
        busy_cnt <= 8'(T_RST);
        F_RB     <= 1'b0;
      end else if (!F_RB) begin
        busy_cnt <= busy_cnt - 8'd1;
        if (busy_cnt <= 8'd1) begin
          busy_cnt <= '0;
          F_RB     <= 1'b1;
          case (state)
            StBusyR: state <= StDout;
            StBusyP: begin
              state <= StIdle;
              if (page_prog_cnt != 8'hFF) page_prog_cnt <= page_prog_cnt + 8'd1;
            end
            default: state <= StIdle;
          endcase
        end
      end else if (is_cmd) begin
        if (cmd_slot && io_in == 8'h00) begin
          state    <= StRaddr;
          addr_cnt <= '0;
        end else if (cmd_slot && io_in == 8'h80) begin
          state    <= StWaddr;
          addr_cnt <= '0;
        end else if (state == StDin && io_in == 8'h10) begin
          state    <= StBusyP;
          busy_cnt <= 8'(T_PROG);
          F_RB     <= 1'b0;
        end
      end else if (is_addr && (state == StRaddr || state == StWaddr) && addr_cnt < N_ADDR) begin
        // Rows beyond 8 bits do not exist for PAGES <= 256, so the row-high cycle is dropped.
        case (addr_cnt)
          4'd0:    column <= COL_W'(io_in);
          4'd1:    row    <= ROW_W'(io_in);
          default: ;
        endcase
        addr_cnt <= addr_cnt + 4'd1;
        if (addr_cnt == N_ADDR - 4'd1) begin
          if (state == StRaddr) begin
            state    <= StBusyR;
            busy_cnt <= 8'(T_R);
            F_RB     <= 1'b0;
          end else begin
            state <= StDin;
          end
        end
      end else if (buf_wr) begin
        column <= column + 1'b1;
      end else if (ren_rise && state == StDout) begin
        column <= column + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_fill) begin
      for (int unsigned i = 0; i < PAGE_SIZE; i++) pbuf[i] <= 8'hFF;
    end else if (buf_wr) begin
      pbuf[column] <= io_in;
    end
    if (commit) begin
      for (int unsigned i = 0; i < PAGE_SIZE; i++) mem_n[row][i] <= mem_n[row][i] | ~pbuf[i];
    end
  end

`ifdef NAND_EMU_STATUS_READ_EN
  logic status_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_mode <= 1'b0;
    end else if (is_cmd) begin
      status_mode <= (io_in == 8'h70);
    end
  end

  always_comb begin
    io_oe  = 1'b0;
    io_out = dout_q;
    if (!host_owns_bus) begin
      if (status_mode) begin
        io_oe  = 1'b1;
        io_out = {F_RB, F_RB, 6'b0};
      end else if (state == StDout && F_RB) begin
        io_oe = 1'b1;
      end
    end
  end
`else
  always_comb begin
    io_out = dout_q;
    io_oe  = !host_owns_bus && (state == StDout) && F_RB;
  end
`endif

  assign F_IO = io_oe ? io_out : 8'hzz;

endmodule

// File: tb/tb_nand_flash_emu.sv
// Directed + randomized bench for nand_flash_emu against a page-level behavioural model.
module tb_nand_flash_emu;
  localparam int PS = 32;
  localparam int NP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cle = 1'b0, ale = 1'b0, wen = 1'b1, ren = 1'b1;
  logic       rb;
  logic [7:0] busy_cnt, page_prog_cnt;
  logic [7:0] tb_io = 8'h00;
  logic       tb_oe = 1'b0;
  wire  [7:0] f_io;

  assign f_io = tb_oe ? tb_io : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (f_io[g]);
  end

  nand_flash_emu dut (
    .clk(clk), .rst(rst), .F_IO(f_io), .F_CLE(cle), .F_ALE(ale), .F_WEN(wen), .F_REN(ren),
    .F_RB(rb), .busy_cnt(busy_cnt), .page_prog_cnt(page_prog_cnt)
  );

  always #5 clk = ~clk;

  int         ncmp = 0;
  int         nfail = 0;
  logic [7:0] mem_m [NP][PS];
  int         prog_m = 0;
  logic [7:0] dq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic c, input logic a, input logic [7:0] d);
    cle = c; ale = a; tb_io = d; tb_oe = 1'b1;
    wen = 1'b0;
    tick;
    wen = 1'b1;
    tick;
    tb_oe = 1'b0; cle = 1'b0; ale = 1'b0;
    #1;
  endtask

  task automatic wait_rdy(input string tag, input int exp_n);
    int n = 0;
    while (rb === 1'b0 && n < 300) begin
      n++;
      tick;
    end
    chk(tag, 8'(n), 8'(exp_n));
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    chk(tag, f_io, exp);
    ren = 1'b0;
    tick;
    ren = 1'b1;
    tick;
    tick;
  endtask

  task automatic send_addr(input int c, input int p);
    bus_wr(1'b0, 1'b1, 8'(c));
    bus_wr(1'b0, 1'b1, 8'(p));
    bus_wr(1'b0, 1'b1, 8'h00);
  endtask

  // Program dq into page p from column c: FFh-filled buffer, wrapping writes, then AND into page.
  task automatic prog_page(input int p, input int c);
    logic [7:0] pb [PS];
    for (int i = 0; i < PS; i++) pb[i] = 8'hFF;
    bus_wr(1'b1, 1'b0, 8'h80);
    send_addr(c, p);
    for (int k = 0; k < dq.size(); k++) begin
      bus_wr(1'b0, 1'b0, dq[k]);
      pb[(c + k) % PS] = dq[k];
    end
    bus_wr(1'b1, 1'b0, 8'h10);
    chk("prog_busy_cnt", busy_cnt, 8'd16);
    for (int i = 0; i < PS; i++) mem_m[p][i] = mem_m[p][i] & pb[i];
    if (prog_m < 255) prog_m++;
    wait_rdy("prog_busy_len", 16);
    chk("prog_cnt", page_prog_cnt, 8'(prog_m));
  endtask

  task automatic read_page(input int p, input int c, input int n);
    bus_wr(1'b1, 1'b0, 8'h00);
    send_addr(c, p);
    wait_rdy("read_busy_len", 8);
    for (int k = 0; k < n; k++) read_chk("read_data", mem_m[p][(c + k) % PS]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < PS; i++) mem_m[p][i] = 8'hFF;

    tick; tick; tick;
    chk("reset_rb", 8'(rb), 8'd1);
    chk("reset_busy_cnt", busy_cnt, 8'd0);
    chk("reset_prog_cnt", page_prog_cnt, 8'd0);
    chk("reset_io_hiz", f_io, 8'hFF);
    rst = 1'b1;
    tick;

    // Reset in the middle of a program: nothing commits, counter stays put.
    bus_wr(1'b1, 1'b0, 8'h80);
    send_addr(0, 7);
    for (int k = 0; k < PS; k++) bus_wr(1'b0, 1'b0, 8'($urandom_range(0, 254)));
    bus_wr(1'b1, 1'b0, 8'h10);
    repeat (5) tick;
    chk("busy_p_rb", 8'(rb), 8'd0);
    rst = 1'b0;
    #1;
    chk("async_rst_rb", 8'(rb), 8'd1);
    chk("async_rst_busy", busy_cnt, 8'd0);
    chk("async_rst_prog_cnt", page_prog_cnt, 8'd0);
    tick;
    rst = 1'b1;
    tick;
    read_page(7, 0, PS);

    // Reset command timing.
    bus_wr(1'b1, 1'b0, 8'hFF);
    chk("ff_busy_cnt", busy_cnt, 8'd4);
    wait_rdy("ff_busy_len", 4);
    read_page(7, 5, 2);

    // Program page 3 with 00..1F, then read it all back.
    dq.delete();
    for (int k = 0; k < PS; k++) dq.push_back(8'(k));
    prog_page(3, 0);
    read_page(3, 0, PS);
    bus_wr(1'b1, 1'b0, 8'h00);
    chk("io_hiz_after_cmd", f_io, 8'hFF);
    bus_wr(1'b1, 1'b0, 8'hFF);
    wait_rdy("ff_busy_len2", 4);

    read_page(3, 30, 4);

    // AND-program: AAh then 0Fh leaves 0Ah.
    dq.delete();
    repeat (PS) dq.push_back(8'hAA);
    prog_page(5, 0);
    dq.delete();
    repeat (PS) dq.push_back(8'h0F);
    prog_page(5, 0);
    read_page(5, 0, PS);
    read_page(9, 0, 4);

    // Randomized programs with wrapping data bursts, each read back from a random column.
    for (int it = 0; it < 6; it++) begin
      int p, c, n;
      p = int'($urandom_range(0, NP - 1));
      c = int'($urandom_range(0, PS - 1));
      n = int'($urandom_range(1, 40));
      dq.delete();
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      prog_page(p, c);
      read_page(p, int'($urandom_range(0, PS - 1)), 8);
    end

    // 70h issued while a read is busy.
    bus_wr(1'b1, 1'b0, 8'h00);
    send_addr(0, 3);
    bus_wr(1'b1, 1'b0, 8'h70);
`ifdef NAND_EMU_STATUS_READ_EN
    chk("status_busy", f_io, 8'h00);
    wait_rdy("status_busy_resume", 6);
    chk("status_ready", f_io, 8'hC0);
`else
    chk("no_status_hiz", f_io, 8'hFF);
    wait_rdy("no_status_busy", 6);
    chk("no_status_dout", f_io, mem_m[3][0]);
`endif
    read_page(3, 4, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
